// File: rtl/pipe_pkg.sv
// Shared types for the decode->execute pipeline stage: skid-buffer state
// encoding and a helper that maps a state onto its entry count.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } pipe_state_t;

    function automatic logic [1:0] occ_of(input pipe_state_t s);
        logic [1:0] occ;
        case (s)
            ST_EMPTY: occ = 2'd0;
            ST_ONE:   occ = 2'd1;
            ST_TWO:   occ = 2'd2;
            default:  occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One payload register of the skid buffer; clear wins over load so a flush
// always restores the reset pattern.
module pipe_slot #(
    parameter int unsigned           WIDTH     = 16,
    parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_r;

    // payload register with synchronous clear/load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r <= RESET_VAL;
        end else if (clear) begin
            q_r <= RESET_VAL;
        end else if (load) begin
            q_r <= d;
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/pipe_stage_reg.sv
// Two-entry skid buffer carrying one bundled decode->execute payload.
// Handshake flags and occupancy are flops; out_data is the head slot itself.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int unsigned      CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    pipe_state_t      state_r;
    pipe_state_t      state_s;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [1:0]       occupancy_r;
    logic [CNT_W-1:0] stall_r;

    logic             push_s;
    logic             pop_s;
    logic             head_load_s;
    logic             head_clear_s;
    logic [WIDTH-1:0] head_d_s;
    logic             skid_load_s;
    logic             skid_clear_s;
    logic [WIDTH-1:0] head_q_s;
    logic [WIDTH-1:0] skid_q_s;

    assign push_s = in_valid & in_ready_r;
    assign pop_s  = out_valid_r & out_ready;

    // next-state and slot control; a popping head is cleared so an empty
    // stage presents the reset pattern
    always_comb begin
        state_s      = state_r;
        head_load_s  = 1'b0;
        head_clear_s = 1'b0;
        head_d_s     = in_data;
        skid_load_s  = 1'b0;
        skid_clear_s = 1'b0;
        if (flush) begin
            state_s      = ST_EMPTY;
            head_clear_s = 1'b1;
            skid_clear_s = 1'b1;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (push_s) begin
                        state_s     = ST_ONE;
                        head_load_s = 1'b1;
                    end else begin
                        state_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (push_s && pop_s) begin
                        head_load_s = 1'b1;
                    end else if (push_s) begin
                        state_s     = ST_TWO;
                        skid_load_s = 1'b1;
                    end else if (pop_s) begin
                        state_s      = ST_EMPTY;
                        head_clear_s = 1'b1;
                    end else begin
                        state_s = ST_ONE;
                    end
                end
                ST_TWO: begin
                    if (pop_s) begin
                        state_s      = ST_ONE;
                        head_load_s  = 1'b1;
                        head_d_s     = skid_q_s;
                        skid_clear_s = 1'b1;
                    end else begin
                        state_s = ST_TWO;
                    end
                end
                default: begin
                    state_s      = ST_EMPTY;
                    head_clear_s = 1'b1;
                    skid_clear_s = 1'b1;
                end
            endcase
        end
    end

    // state and handshake flags, all registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_EMPTY;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            occupancy_r <= 2'd0;
        end else begin
            state_r     <= state_s;
            out_valid_r <= (state_s != ST_EMPTY);
            in_ready_r  <= (state_s != ST_TWO);
            occupancy_r <= occ_of(state_s);
        end
    end

    // saturating backpressure counter; flush deliberately leaves it alone
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_r <= '0;
        end else if (out_valid_r && !out_ready && (stall_r != {CNT_W{1'b1}})) begin
            stall_r <= stall_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_r <= stall_r;
        end
    end

    pipe_slot #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_head (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (head_clear_s),
        .load  (head_load_s),
        .d     (head_d_s),
        .q     (head_q_s)
    );

    pipe_slot #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (skid_clear_s),
        .load  (skid_load_s),
        .d     (in_data),
        .q     (skid_q_s)
    );

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = head_q_s;
    assign occupancy = occupancy_r;
    assign stall_cnt = stall_r;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: handshake, ordering, flush, stall
// saturation, async reset, plus a short randomized queue comparison.
module tb_pipe_stage_reg;

    localparam int unsigned      WIDTH = 16;
    localparam logic [15:0]      RV    = 16'h5A5A;
    localparam int unsigned      CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       occupancy;
    logic [CNT_W-1:0] stall_cnt;

    int pass_cnt = 0;
    int total    = 0;

    pipe_stage_reg #(.WIDTH(WIDTH), .RESET_VAL(RV), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic v, input logic r,
                             input logic [1:0] occ, input logic [15:0] d);
        chk({tag, "_out_valid"}, {31'd0, out_valid}, {31'd0, v});
        chk({tag, "_in_ready"},  {31'd0, in_ready},  {31'd0, r});
        chk({tag, "_occupancy"}, {30'd0, occupancy}, {30'd0, occ});
        chk({tag, "_out_data"},  {16'd0, out_data},  {16'd0, d});
    endtask

    initial begin
        logic [15:0] q[$];
        int          cnt;
        logic        push;
        logic        pop;
        logic        rdy_before;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 16'h0000; out_ready = 1'b0;
        #12;
        chk_state("reset", 1'b0, 1'b1, 2'd0, RV);
        chk("reset_stall", {29'd0, stall_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // single push with downstream ready
        in_valid = 1'b1; in_data = 16'h00A5; out_ready = 1'b1;
        step();
        chk_state("push1", 1'b1, 1'b1, 2'd1, 16'h00A5);
        in_valid = 1'b0;
        step();
        chk_state("pop1", 1'b0, 1'b1, 2'd0, RV);

        // fill under backpressure, refused third offer, then drain in order
        out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0001;
        step();
        chk_state("fill1", 1'b1, 1'b1, 2'd1, 16'h0001);
        in_data = 16'h0002;
        step();
        chk_state("fill2", 1'b1, 1'b0, 2'd2, 16'h0001);
        in_data = 16'h0003;
        step();
        chk_state("refuse3", 1'b1, 1'b0, 2'd2, 16'h0001);
        chk("stall_fill", {29'd0, stall_cnt}, 32'd2);
        out_ready = 1'b1;
        step();
        chk_state("drain2", 1'b1, 1'b1, 2'd1, 16'h0002);
        step();
        chk_state("drain3", 1'b1, 1'b1, 2'd1, 16'h0003);
        in_valid = 1'b0;
        step();
        chk_state("drained", 1'b0, 1'b1, 2'd0, RV);

        // flush from TWO discards held and incoming entries
        out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0011;
        step();
        in_data = 16'h0022;
        step();
        chk_state("pre_flush", 1'b1, 1'b0, 2'd2, 16'h0011);
        flush = 1'b1; in_data = 16'h0BAD;
        step();
        chk_state("flush", 1'b0, 1'b1, 2'd0, RV);
        chk("stall_kept", {29'd0, stall_cnt}, 32'd4);
        flush = 1'b0; in_valid = 1'b0;
        step();
        chk_state("post_flush", 1'b0, 1'b1, 2'd0, RV);

        // stall counter saturates at 7 and holds
        in_valid = 1'b1; in_data = 16'h0033;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk("stall_sat", {29'd0, stall_cnt}, 32'd7);
        step();
        chk("stall_hold", {29'd0, stall_cnt}, 32'd7);

        // asynchronous reset between edges while full
        in_valid = 1'b1; in_data = 16'h0044;
        step();
        chk_state("pre_areset", 1'b1, 1'b0, 2'd2, 16'h0033);
        #2;
        rst_n = 1'b0;
        #1;
        chk_state("areset", 1'b0, 1'b1, 2'd0, RV);
        chk("areset_stall", {29'd0, stall_cnt}, 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk_state("after_areset", 1'b0, 1'b1, 2'd0, RV);

        // randomized traffic against a reference queue
        cnt = 0;
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 99) < 60);
            in_data   = 16'($urandom);
            out_ready = ($urandom_range(0, 99) < 50);
            chk("rnd_valid", {31'd0, out_valid}, {31'd0, (cnt > 0)});
            chk("rnd_ready", {31'd0, in_ready}, {31'd0, (cnt < 2)});
            if (cnt > 0) chk("rnd_data", {16'd0, out_data}, {16'd0, q[0]});
            else         chk("rnd_idle", {16'd0, out_data}, {16'd0, RV});
            rdy_before = in_ready;
            out_ready = ~out_ready;
            #1;
            chk("rnd_comb", {31'd0, in_ready}, {31'd0, rdy_before});
            out_ready = ~out_ready;
            push = in_valid && (cnt < 2);
            pop  = (cnt > 0) && out_ready;
            if (pop) begin
                void'(q.pop_front());
                cnt--;
            end
            if (push) begin
                q.push_back(in_data);
                cnt++;
            end
            step();
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
